port_share_arbiter: RTL



---
 rtl/port_share_pkg.sv | 29 ++
 rtl/port_share_arbiter_chk.sv | 20 ++
 rtl/shared_add_pipe.sv | 48 ++++
 rtl/port_share_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/port_share_pkg.sv
// Shared types and the round-robin winner search for port_share_arbiter.
// Types are sized for the default configuration; the top sizes its own storage from its parameters.
package port_share_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int MAX_REQ     = 32;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] z;
    req_id_t              id;
  } resp_t;

  // Lowest valid index at or after ptr; if none, lowest valid index overall; -1 if nothing valid.
  function automatic int next_rr_winner(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    int lo;
    int hi;
    lo = -1;
    hi = -1;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      lo = (i < n && valid[i]) ? i : lo;
      hi = (i < n && i >= ptr && valid[i]) ? i : hi;
    end
    return (hi >= 0) ? hi : lo;
  endfunction

endpackage

// File: rtl/port_share_arbiter_chk.sv
// Simulation-only invariants for the response buffer credit scheme.
module port_share_arbiter_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] fifo_count,
  input logic [CW-1:0] in_flight
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, in_flight} + {1'b0, fifo_count}) <= (CW+1)'(FIFO_DEPTH)));

endmodule

// File: rtl/shared_add_pipe.sv
// Non-stallable LATENCY-stage adder; valid and id tag travel alongside the sum.
module shared_add_pipe
  import port_share_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [ID_W-1:0]  in_id,
  output logic             out_valid,
  output logic [WIDTH-1:0] z,
  output logic [ID_W-1:0]  out_id
);

  logic             r_valid [LATENCY];
  logic [WIDTH-1:0] r_z     [LATENCY];
  logic [ID_W-1:0]  r_id    [LATENCY];

  // Sum is formed on entry; later stages only delay it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_valid[s] <= 1'b0;
        r_z[s]     <= '0;
        r_id[s]    <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_z[0]     <= in1 + in2;
      r_id[0]    <= in_id;
      for (int s = 1; s < LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_z[s]     <= r_z[s-1];
        r_id[s]    <= r_id[s-1];
      end
    end
  end

  assign out_valid = r_valid[LATENCY-1];
  assign z         = r_z[LATENCY-1];
  assign out_id    = r_id[LATENCY-1];

endmodule

// File: rtl/port_share_arbiter.sv
// Round-robin, credit-gated sharing of one pipelined adder among NUM_REQ requesters,
// with an in-order first-word-fall-through response buffer.
module port_share_arbiter
  import port_share_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_in1,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_in2,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [WIDTH-1:0]                  resp_z,
  output logic [$clog2(NUM_REQ)-1:0]        resp_id
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic [ID_W-1:0]  id;
  } entry_t;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [CW-1:0]    r_in_flight;
  logic [CW-1:0]    r_fifo_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  entry_t           r_mem [FIFO_DEPTH];

  int               w_win;
  logic             w_credit;
  logic             w_grant;
  logic [ID_W-1:0]  w_win_id;
  logic             w_pipe_valid;
  logic             w_pop;
  logic [WIDTH-1:0] z;
  logic [ID_W-1:0]  out_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits come from registered counts only, so a pop frees its slot one cycle later.
  always_comb begin
    w_win    = next_rr_winner(MAX_REQ'(req_valid), int'(r_rr_ptr), NUM_REQ);
    w_credit = (({1'b0, r_in_flight} + {1'b0, r_fifo_count}) < (CW+1)'(FIFO_DEPTH));
    w_grant  = w_credit && !rst && (w_win >= 0);
    w_win_id = (w_win >= 0) ? ID_W'(w_win) : '0;
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_win_id] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  shared_add_pipe #(
    .WIDTH   (WIDTH),
    .ID_W    (ID_W),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_grant),
    .in1       (req_in1[w_win_id]),
    .in2       (req_in2[w_win_id]),
    .in_id     (w_win_id),
    .out_valid (w_pipe_valid),
    .z,
    .out_id
  );

  assign resp_valid = (r_fifo_count != '0);
  assign w_pop      = resp_valid && resp_ready;
  assign resp_z     = r_mem[r_rd_ptr].z;
  assign resp_id    = r_mem[r_rd_ptr].id;

  // Round-robin pointer and the count of results still inside the adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_in_flight <= '0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + ID_W'(1);
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
      case ({w_grant, w_pipe_valid})
        2'b10:   r_in_flight <= r_in_flight + CW'(1);
        2'b01:   r_in_flight <= r_in_flight - CW'(1);
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

  // Response buffer: pipe output is always written; the credit rule guarantees room.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_pipe_valid) begin
        r_mem[r_wr_ptr] <= '{z: z, id: out_id};
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_pipe_valid, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + CW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - CW'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  port_share_arbiter_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .push       (w_pipe_valid),
    .pop        (w_pop),
    .fifo_count (r_fifo_count),
    .in_flight  (r_in_flight)
  );

endmodule
